// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access over a req/ack handshake, branch resolve,
// and the MEM/WB pipeline register with bubble insertion on stall or timeout abort.
module mem_stage #(
  parameter int ADDR_BITS = 10,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          aluResult,
  input  logic [31:0]          writeData,
  input  logic [6:0]           branchAddress,
  input  logic [4:0]           rd,
  input  logic [1:0]           wb,
  input  logic                 ZF,
  input  logic                 memRead,
  input  logic                 memWrite,
  input  logic                 branch,
  input  logic                 BNE,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [ADDR_BITS-1:0] dmem_addr,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_ack,
  output logic                 stall,
  output logic                 pcSrc,
  output logic [6:0]           branchTarget,
  output logic                 memError,
  output logic [31:0]          wbReadData,
  output logic [31:0]          wbAluResult,
  output logic [4:0]           wbRd,
  output logic [1:0]           wbCtrl
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic        mem_error_q, mem_error_d;
  logic [31:0] wb_read_data_q, wb_read_data_d;
  logic [31:0] wb_alu_result_q, wb_alu_result_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [1:0]  wb_ctrl_q, wb_ctrl_d;

  logic access;
  logic abort;
  logic timeout;

  assign access       = memRead | memWrite;
  assign dmem_req     = ~reset & access;
  assign dmem_we      = memWrite;
  assign dmem_addr    = aluResult[ADDR_BITS+1:2];
  assign dmem_wdata   = writeData;
  assign abort        = (state_q == S_WAIT) && (count_q == LAST_COUNT);
  // An ack arriving on the last allowed cycle still completes the access normally.
  assign timeout      = abort & dmem_req & ~dmem_ack;
  assign stall        = dmem_req & ~dmem_ack & ~abort;
  assign pcSrc        = branch & (ZF ^ BNE);
  assign branchTarget = branchAddress;

  assign memError    = mem_error_q;
  assign wbReadData  = wb_read_data_q;
  assign wbAluResult = wb_alu_result_q;
  assign wbRd        = wb_rd_q;
  assign wbCtrl      = wb_ctrl_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mem_error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dmem_req && !dmem_ack) begin
          state_d = S_WAIT;
          count_d = 8'd0;
        end
      end
      S_WAIT: begin
        if (dmem_ack || !dmem_req) begin
          state_d = S_IDLE;
        end else if (abort) begin
          state_d     = S_IDLE;
          mem_error_d = 1'b1;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wb_read_data_d  = wb_read_data_q;
    wb_alu_result_d = wb_alu_result_q;
    wb_rd_d         = wb_rd_q;
    wb_ctrl_d       = wb_ctrl_q;
    if (stall || timeout) begin
      wb_ctrl_d = 2'b00;
    end else begin
      wb_alu_result_d = aluResult;
      wb_rd_d         = rd;
      wb_ctrl_d       = wb;
      if (memRead && !memWrite && dmem_ack) begin
        wb_read_data_d = dmem_rdata;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      count_q         <= 8'd0;
      mem_error_q     <= 1'b0;
      wb_read_data_q  <= 32'd0;
      wb_alu_result_q <= 32'd0;
      wb_rd_q         <= 5'd0;
      wb_ctrl_q       <= 2'b00;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      mem_error_q     <= mem_error_d;
      wb_read_data_q  <= wb_read_data_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_rd_q         <= wb_rd_d;
      wb_ctrl_q       <= wb_ctrl_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, hand-written multi-cycle sequences,
// and randomized instructions checked against a pending-cycle-count reference model.
module tb_mem_stage;
  localparam int ADDR_BITS = 10;
  localparam int TIMEOUT   = 15;

  logic clock = 1'b0;
  logic reset;
  logic [31:0] aluResult, writeData, dmem_rdata;
  logic [6:0]  branchAddress;
  logic [4:0]  rd;
  logic [1:0]  wb;
  logic ZF, memRead, memWrite, branch, BNE, dmem_ack;
  logic dmem_req, dmem_we, stall, pcSrc, memError;
  logic [ADDR_BITS-1:0] dmem_addr;
  logic [31:0] dmem_wdata, wbReadData, wbAluResult;
  logic [6:0]  branchTarget;
  logic [4:0]  wbRd;
  logic [1:0]  wbCtrl;

  mem_stage #(.ADDR_BITS(ADDR_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .aluResult(aluResult), .writeData(writeData),
    .branchAddress(branchAddress), .rd(rd), .wb(wb), .ZF(ZF), .memRead(memRead),
    .memWrite(memWrite), .branch(branch), .BNE(BNE), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall), .pcSrc(pcSrc),
    .branchTarget(branchTarget), .memError(memError), .wbReadData(wbReadData),
    .wbAluResult(wbAluResult), .wbRd(wbRd), .wbCtrl(wbCtrl)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: MEM/WB contents plus how many cycles the current request has been pending.
  logic [31:0] m_rdata, m_alu;
  logic [4:0]  m_rd;
  logic [1:0]  m_ctrl;
  logic        m_err;
  int          m_k;

  logic        obs_req, obs_we, obs_stall, obs_pc;
  logic [ADDR_BITS-1:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [6:0]  obs_bt;

  typedef struct {
    logic mr, mw, br, zf, bne, ack;
    logic [31:0] alu, wd, rdata;
    logic [4:0] rd;
    logic [1:0] wb;
    logic e_req, e_we, e_stall, e_pc;
    logic [9:0] e_addr;
    logic [31:0] e_wbalu, e_wbrdata;
    logic [1:0] e_wbctrl;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rdata = '0; m_alu = '0; m_rd = '0; m_ctrl = '0; m_err = 1'b0; m_k = 0;
  endtask

  task automatic drive(input logic mr, input logic mw, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] r, input logic [1:0] w,
                       input logic br, input logic zf, input logic bne);
    memRead = mr; memWrite = mw; aluResult = alu; writeData = wd; rd = r; wb = w;
    branch = br; ZF = zf; BNE = bne;
  endtask

  // Called just after inputs change at a negedge; returns at the following negedge.
  task automatic run_cycle(input string tag);
    logic req, exp_stall, exp_abort;
    #1;
    req       = memRead | memWrite;
    exp_stall = req & ~dmem_ack & (m_k < TIMEOUT);
    exp_abort = req & ~dmem_ack & (m_k >= TIMEOUT);
    obs_req = dmem_req; obs_we = dmem_we; obs_stall = stall; obs_pc = pcSrc;
    obs_addr = dmem_addr; obs_wdata = dmem_wdata; obs_bt = branchTarget;
    chk({tag, ".req"}, dmem_req, req);
    if (req) begin
      chk({tag, ".we"}, dmem_we, memWrite);
      chk({tag, ".addr"}, dmem_addr, aluResult[ADDR_BITS+1:2]);
      chk({tag, ".wdata"}, dmem_wdata, writeData);
    end
    chk({tag, ".stall"}, stall, exp_stall);
    chk({tag, ".pcSrc"}, pcSrc, (branch && (ZF != BNE)) ? 1 : 0);
    chk({tag, ".btgt"}, branchTarget, branchAddress);
    @(posedge clock);
    if (exp_stall) begin
      m_ctrl = 2'b00; m_err = 1'b0; m_k++;
    end else if (exp_abort) begin
      m_ctrl = 2'b00; m_err = 1'b1; m_k = 0;
    end else begin
      m_alu = aluResult; m_rd = rd; m_ctrl = wb; m_err = 1'b0; m_k = 0;
      if (memRead && !memWrite && dmem_ack) m_rdata = dmem_rdata;
    end
    #1;
    chk({tag, ".wbReadData"}, wbReadData, m_rdata);
    chk({tag, ".wbAluResult"}, wbAluResult, m_alu);
    chk({tag, ".wbRd"}, wbRd, m_rd);
    chk({tag, ".wbCtrl"}, wbCtrl, m_ctrl);
    chk({tag, ".memError"}, memError, m_err);
    @(negedge clock);
  endtask

  initial begin
    int stall_cnt;
    bit never_ack;
    logic mr, mw;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 32'h0, 5'd5, 2'b10,
                1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h1234, 32'h0, 2'b10};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'hCAFE, 32'h9999, 5'd7, 2'b00,
                1'b1, 1'b1, 1'b0, 1'b0, 10'd2, 32'h8, 32'h0, 2'b00};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 5'd1, 2'b10,
                1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 32'h100, 32'h0, 2'b10};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 32'h0, 5'd2, 2'b10,
                1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h104, 32'h0, 2'b10};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h108, 32'h0, 32'h0, 5'd3, 2'b10,
                1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 32'h108, 32'h0, 2'b10};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10C, 32'h0, 32'h0, 5'd4, 2'b10,
                1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'h10C, 32'h0, 2'b10};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC, 32'h77, 32'h5555, 5'd6, 2'b01,
                1'b1, 1'b1, 1'b0, 1'b0, 10'd3, 32'hC, 32'h0, 2'b01};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h0, 32'h11112222, 5'd9, 2'b11,
                1'b1, 1'b0, 1'b0, 1'b0, 10'h11, 32'h44, 32'h11112222, 2'b11};

    // Reset with a load pending: req must stay low, registers cleared.
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0; branchAddress = 7'h55;
    drive(1'b1, 1'b0, 32'h40, 32'h0, 5'd5, 2'b11, 1'b0, 1'b0, 1'b0);
    model_reset();
    #3;
    chk("rst.req", dmem_req, 0);
    chk("rst.wbCtrl", wbCtrl, 0);
    chk("rst.wbAluResult", wbAluResult, 0);
    chk("rst.wbReadData", wbReadData, 0);
    chk("rst.memError", memError, 0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].mr, vecs[i].mw, vecs[i].alu, vecs[i].wd, vecs[i].rd, vecs[i].wb,
            vecs[i].br, vecs[i].zf, vecs[i].bne);
      dmem_ack = vecs[i].ack; dmem_rdata = vecs[i].rdata;
      run_cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.t_req", i), obs_req, vecs[i].e_req);
      if (vecs[i].e_req) begin
        chk($sformatf("vec%0d.t_we", i), obs_we, vecs[i].e_we);
        chk($sformatf("vec%0d.t_addr", i), obs_addr, vecs[i].e_addr);
        chk($sformatf("vec%0d.t_wdata", i), obs_wdata, vecs[i].wd);
      end
      chk($sformatf("vec%0d.t_stall", i), obs_stall, vecs[i].e_stall);
      chk($sformatf("vec%0d.t_pc", i), obs_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d.t_bt", i), obs_bt, 7'h55);
      chk($sformatf("vec%0d.t_wbalu", i), wbAluResult, vecs[i].e_wbalu);
      chk($sformatf("vec%0d.t_wbrdata", i), wbReadData, vecs[i].e_wbrdata);
      chk($sformatf("vec%0d.t_wbctrl", i), wbCtrl, vecs[i].e_wbctrl);
    end

    // Load acked on the third request cycle.
    drive(1'b1, 1'b0, 32'h40, 32'h0, 5'd12, 2'b11, 1'b0, 1'b0, 1'b0);
    stall_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      dmem_ack = (c == 2); dmem_rdata = (c == 2) ? 32'hDEADBEEF : 32'h0BAD0BAD;
      run_cycle($sformatf("load3.c%0d", c));
      if (obs_stall) stall_cnt++;
      chk("load3.addr", obs_addr, 16);
      if (c < 2) chk("load3.bubble", wbCtrl, 0);
    end
    chk("load3.stall_cycles", stall_cnt, 2);
    chk("load3.rdata", wbReadData, 32'hDEADBEEF);
    chk("load3.ctrl", wbCtrl, 2'b11);
    chk("load3.rd", wbRd, 12);

    // Load never acked: aborted after the timeout.
    drive(1'b1, 1'b0, 32'h80, 32'h0, 5'd13, 2'b11, 1'b0, 1'b0, 1'b0);
    dmem_ack = 1'b0;
    stall_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      run_cycle("tmo");
      if (!obs_stall) break;
      stall_cnt++;
    end
    chk("tmo.stall_cycles", stall_cnt, TIMEOUT);
    chk("tmo.memError", memError, 1);
    chk("tmo.ctrl", wbCtrl, 0);
    chk("tmo.rdata_kept", wbReadData, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    run_cycle("tmo.after");
    chk("tmo.pulse_end", memError, 0);

    // Reset asserted during the second WAIT cycle of a load.
    drive(1'b0, 1'b0, 32'h3C, 32'h0, 5'd21, 2'b10, 1'b0, 1'b0, 1'b0);
    run_cycle("prewait");
    drive(1'b1, 1'b0, 32'hC0, 32'h0, 5'd22, 2'b11, 1'b0, 1'b0, 1'b0);
    dmem_ack = 1'b0;
    run_cycle("rw.c0");
    run_cycle("rw.c1");
    #1 reset = 1'b1;
    #1;
    chk("rw.req", dmem_req, 0);
    chk("rw.wbReadData", wbReadData, 0);
    chk("rw.wbAluResult", wbAluResult, 0);
    chk("rw.wbRd", wbRd, 0);
    chk("rw.wbCtrl", wbCtrl, 0);
    chk("rw.memError", memError, 0);
    model_reset();
    @(negedge clock);
    memRead = 1'b0;
    reset = 1'b0;
    run_cycle("rw.after");
    chk("rw.stall", obs_stall, 0);
    chk("rw.noerr", memError, 0);
    run_cycle("rw.after2");
    chk("rw.noerr2", memError, 0);

    // Randomized instruction stream, inputs held while stalled.
    for (int n = 0; n < 250; n++) begin
      mr = ($urandom_range(0, 2) == 0);
      mw = ($urandom_range(0, 3) == 0);
      never_ack = ($urandom_range(0, 9) == 0);
      drive(mr, mw, $urandom, $urandom, 5'($urandom), 2'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
      branchAddress = 7'($urandom);
      for (int c = 0; c < TIMEOUT + 4; c++) begin
        dmem_ack = never_ack ? 1'b0 : ($urandom_range(0, 2) == 0);
        dmem_rdata = $urandom;
        run_cycle($sformatf("rnd%0d.c%0d", n, c));
        if (!obs_stall) break;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
